// File: rtl/rom_dbg_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rom_dbg_arbiter_pkg
// Shared types and constants for the i4001 debug-port arbiter.
//   char_t / byte_t   : MCS-4 nibble and byte
//   dbg_addr_t        : 12-bit debug address, [11:8] ROM_ID, [7:0] byte addr
//   dbg_op_t          : latched command type
//   rom_dbg_state_t   : arbiter FSM states
//   Dbg_err_data      : read data returned on timeout
//   more_than_one()   : detects two or more set bits in a valid vector
// ---------------------------------------------------------------------------
package rom_dbg_arbiter_pkg;

    typedef logic [3:0] char_t;
    typedef logic [7:0] byte_t;
    typedef char_t [2:0] dbg_addr_t;

    typedef enum logic {
        DBG_RD = 1'b0,
        DBG_WR = 1'b1
    } dbg_op_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        VERIFY_ISSUE,
        RESP
    } rom_dbg_state_t;

    localparam byte_t Dbg_err_data = 8'hFF;

    // x & (x-1) clears the lowest set bit; anything left means a collision.
    function automatic logic more_than_one(input logic [15:0] v);
        return (v & (v - 16'd1)) != 16'd0;
    endfunction

endpackage

// File: rtl/rom_dbg_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker. Search starts at ptr+1 and wraps, so the
// requester granted last has the lowest priority next time.
// Ports:
//   req        in   NUM_REQ   request vector (already qualified by caller)
//   ptr        in   IDX_W     index of the most recent winner
//   grant      out  NUM_REQ   one-hot grant, zero when no request
//   grant_idx  out  IDX_W     index of the granted requester
//   grant_any  out  1         any request granted
// ---------------------------------------------------------------------------
module rr_arbiter
    import rom_dbg_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       grant_any
);

    localparam int IDX_W = $clog2(NUM_REQ);

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        // First pass: indices above the pointer, in ascending order.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_any && req[i] && (i > int'(ptr))) begin
                grant_any = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = IDX_W'(i);
            end
        end
        // Second pass: wrap around to indices at or below the pointer.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_any && req[i] && (i <= int'(ptr))) begin
                grant_any = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/rom_dbg_arbiter.sv
// ---------------------------------------------------------------------------
// rom_dbg_arbiter
// Shares the i4001 debug port between NUM_REQ requesters. One command is in
// flight at a time; strobes are single-cycle and broadcast to every ROM.
// Read data from the chips is collected and returned as a tagged response;
// a missing ROM_ID times out, a duplicated ROM_ID is flagged as a collision.
//
// Optional build macro: ROM_DBG_WRITE_VERIFY_EN
//   When defined, every write is followed by a readback of the same address
//   and the write response carries the readback data and a mismatch flag.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   grant_en           new grants allowed (low while CPU fetch is protected)
//   req_valid/ready    per-requester handshake, ready is one-hot or zero
//   req_write          per-requester op, 1 = write
//   req_addr           per-requester 12-bit address, packed NUM_REQ x 12
//   req_wdata          per-requester write data, packed NUM_REQ x 8
//   rsp_valid          1-cycle response strobe
//   rsp_id/rdata/err   response tag, data and error flag
//   dbg_addr/wdata     broadcast address and write data
//   dbg_wen/ren        broadcast write/read strobes
//   dbg_rdata_in       per-chip read data, packed NUM_ROMS x 8
//   dbg_rdata_vld_in   per-chip read data valid
//
// State table:
//   IDLE         | waiting for a qualified request, grants combinationally
//   ISSUE        | one-cycle dbg_wen or dbg_ren with latched address/data
//   WAIT         | collecting chip responses, timer running
//   VERIFY_ISSUE | readback strobe after a write (verify build only)
//   RESP         | one-cycle tagged response to the requester
// ---------------------------------------------------------------------------
module rom_dbg_arbiter
    import rom_dbg_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int NUM_ROMS = 16,
    parameter int TIMEOUT  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       grant_en,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ-1:0]         req_write,
    input  logic [NUM_REQ*12-1:0]      req_addr,
    input  logic [NUM_REQ*8-1:0]       req_wdata,
    output logic                       rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [7:0]                 rsp_rdata,
    output logic                       rsp_err,
    output logic [11:0]                dbg_addr,
    output logic [7:0]                 dbg_wdata,
    output logic                       dbg_wen,
    output logic                       dbg_ren,
    input  logic [NUM_ROMS*8-1:0]      dbg_rdata_in,
    input  logic [NUM_ROMS-1:0]        dbg_rdata_vld_in
);

    localparam int          IDX_W      = $clog2(NUM_REQ);
    localparam logic [7:0]  Timer_load = 8'(TIMEOUT);

    rom_dbg_state_t   state_q, state_nxt;
    logic [IDX_W-1:0] ptr_q, ptr_nxt;
    dbg_op_t          op_q, op_nxt;
    dbg_addr_t        addr_q, addr_nxt;
    byte_t            wdata_q, wdata_nxt;
    logic [IDX_W-1:0] id_q, id_nxt;
    logic [7:0]       timer_q, timer_nxt;
    byte_t            rdata_q, rdata_nxt;
    logic             err_q, err_nxt;

    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;

    logic               sel_write;
    logic [11:0]        sel_addr;
    byte_t              sel_wdata;

    byte_t              vld_data;
    logic               vld_any;
    logic               vld_multi;

    // grant_en only gates new grants; an accepted command always completes.
    assign arb_req = req_valid & {NUM_REQ{grant_en}};

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req       (arb_req),
        .ptr       (ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .grant_any (arb_any)
    );

    // Mux the winning requester's command fields.
    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
                sel_write = req_write[i];
                sel_addr  = req_addr[i*12 +: 12];
                sel_wdata = req_wdata[i*8 +: 8];
            end
        end
    end

    // OR of all flagged chips' data; equals the single chip's data when
    // exactly one responds.
    always_comb begin
        vld_data = '0;
        for (int i = 0; i < NUM_ROMS; i++) begin
            if (dbg_rdata_vld_in[i]) begin
                vld_data = vld_data | dbg_rdata_in[i*8 +: 8];
            end
        end
    end

    assign vld_any   = |dbg_rdata_vld_in;
    assign vld_multi = more_than_one(16'(dbg_rdata_vld_in));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
            op_q    <= DBG_RD;
            addr_q  <= '0;
            wdata_q <= '0;
            id_q    <= '0;
            timer_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            ptr_q   <= ptr_nxt;
            op_q    <= op_nxt;
            addr_q  <= addr_nxt;
            wdata_q <= wdata_nxt;
            id_q    <= id_nxt;
            timer_q <= timer_nxt;
            rdata_q <= rdata_nxt;
            err_q   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        ptr_nxt   = ptr_q;
        op_nxt    = op_q;
        addr_nxt  = addr_q;
        wdata_nxt = wdata_q;
        id_nxt    = id_q;
        timer_nxt = timer_q;
        rdata_nxt = rdata_q;
        err_nxt   = err_q;

        req_ready = '0;
        rsp_valid = 1'b0;
        rsp_id    = '0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        dbg_addr  = '0;
        dbg_wdata = '0;
        dbg_wen   = 1'b0;
        dbg_ren   = 1'b0;

        case (state_q)
            IDLE: begin
                // Ready is suppressed while in reset so nothing is handshaken
                // that the reset would then discard.
                if (arb_any && !rst) begin
                    req_ready = arb_grant;
                    op_nxt    = sel_write ? DBG_WR : DBG_RD;
                    addr_nxt  = sel_addr;
                    wdata_nxt = sel_wdata;
                    id_nxt    = arb_idx;
                    ptr_nxt   = arb_idx;
                    state_nxt = ISSUE;
                end
            end

            ISSUE: begin
                dbg_addr  = addr_q;
                dbg_wdata = wdata_q;
                dbg_wen   = (op_q == DBG_WR);
                dbg_ren   = (op_q == DBG_RD);
                if (op_q == DBG_WR) begin
`ifdef ROM_DBG_WRITE_VERIFY_EN
                    state_nxt = VERIFY_ISSUE;
`else
                    rdata_nxt = '0;
                    err_nxt   = 1'b0;
                    state_nxt = RESP;
`endif
                end else begin
                    timer_nxt = Timer_load;
                    state_nxt = WAIT;
                end
            end

`ifdef ROM_DBG_WRITE_VERIFY_EN
            VERIFY_ISSUE: begin
                dbg_addr  = addr_q;
                dbg_ren   = 1'b1;
                timer_nxt = Timer_load;
                state_nxt = WAIT;
            end
`endif

            WAIT: begin
                // Down-counter loaded with TIMEOUT: the wait gives up after
                // TIMEOUT+1 empty sample cycles.
                if (vld_any) begin
                    rdata_nxt = vld_data;
                    err_nxt   = vld_multi;
`ifdef ROM_DBG_WRITE_VERIFY_EN
                    if (op_q == DBG_WR) begin
                        err_nxt = vld_multi || (vld_data != wdata_q);
                    end
`endif
                    state_nxt = RESP;
                end else if (timer_q == 8'd0) begin
                    rdata_nxt = Dbg_err_data;
                    err_nxt   = 1'b1;
                    state_nxt = RESP;
                end else begin
                    timer_nxt = timer_q - 8'd1;
                end
            end

            RESP: begin
                rsp_valid = 1'b1;
                rsp_id    = id_q;
                rsp_rdata = rdata_q;
                rsp_err   = err_q;
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
